zap_wb_fifo_drain: RTL and testbench

ZAP_WB_FIFO_DRAIN -- requirements
Module: zap_wb_fifo_drain

---
 rtl/zap_wb_fifo_drain.sv | 155 +++++++++++++++
 tb/tb_zap_wb_fifo_drain.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/zap_wb_fifo_drain.sv
// Drains a first-word-fall-through write FIFO onto a Wishbone B3 master port,
// merging address-contiguous entries into incrementing bursts of up to MAX_BURST beats.
module zap_wb_fifo_drain #(
  parameter int unsigned MAX_BURST = 32'd8
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [67:0] i_fifo_data,
  input  logic        i_fifo_empty_n,
  output logic        o_fifo_ack,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [31:0] o_wb_adr,
  output logic [3:0]  o_wb_sel,
  output logic [31:0] o_wb_dat,
  output logic [2:0]  o_wb_cti,
  output logic [1:0]  o_wb_bte,
  input  logic        i_wb_ack,
  input  logic        i_wb_err,
  output logic        o_err,
  output logic        o_idle
);

  localparam int unsigned CW = $clog2(MAX_BURST) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BURST - 1);

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PEEK,
    S_STROBE
  } state_t;

  state_t         r_state, w_state_nxt;
  logic           r_cyc, w_cyc_nxt;
  logic           r_stb, w_stb_nxt;
  logic           r_err, w_err_nxt;
  logic [2:0]     r_cti, w_cti_nxt;
  logic [31:0]    r_adr, w_adr_nxt;
  logic [3:0]     r_sel, w_sel_nxt;
  logic [31:0]    r_dat, w_dat_nxt;
  logic [CW-1:0]  r_cnt, w_cnt_nxt;
  logic           w_pop;
  logic [32:0]    w_adr_inc;
  logic           w_cont;

  // 33-bit compare so that 0xFFFFFFFC + 4 can never match address 0.
  assign w_adr_inc = {1'b0, r_adr} + 33'd4;
  assign w_cont    = i_fifo_empty_n
                   && (w_adr_inc == {1'b0, i_fifo_data[67:36]})
                   && (r_cnt < LAST_CNT);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    w_state_nxt = r_state;
    w_cyc_nxt   = r_cyc;
    w_stb_nxt   = r_stb;
    w_err_nxt   = 1'b0;
    w_cti_nxt   = r_cti;
    w_adr_nxt   = r_adr;
    w_sel_nxt   = r_sel;
    w_dat_nxt   = r_dat;
    w_cnt_nxt   = r_cnt;
    w_pop       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_fifo_empty_n) begin
          w_pop       = 1'b1;
          w_cnt_nxt   = '0;
          w_cyc_nxt   = 1'b1;
          w_stb_nxt   = 1'b0;
          w_state_nxt = S_PEEK;
        end
      end
      S_PEEK: begin
        w_cti_nxt   = w_cont ? CTI_INCR : CTI_END;
        w_stb_nxt   = 1'b1;
        w_state_nxt = S_STROBE;
      end
      S_STROBE: begin
        if (i_wb_err) begin
          w_cyc_nxt   = 1'b0;
          w_stb_nxt   = 1'b0;
          w_err_nxt   = 1'b1;
          w_cti_nxt   = CTI_CLASSIC;
          w_state_nxt = S_IDLE;
        end else if (i_wb_ack) begin
          if (r_cti == CTI_INCR) begin
            w_pop       = i_fifo_empty_n;
            w_cnt_nxt   = r_cnt + CW'(1);
            w_stb_nxt   = 1'b0;
            w_state_nxt = S_PEEK;
          end else begin
            w_cyc_nxt   = 1'b0;
            w_stb_nxt   = 1'b0;
            w_cti_nxt   = CTI_CLASSIC;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_pop) begin
      w_adr_nxt = i_fifo_data[67:36];
      w_sel_nxt = i_fifo_data[35:32];
      w_dat_nxt = i_fifo_data[31:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
      r_cyc   <= 1'b0;
      r_stb   <= 1'b0;
      r_err   <= 1'b0;
      r_cti   <= CTI_CLASSIC;
      r_adr   <= '0;
      r_sel   <= '0;
      r_dat   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cyc   <= w_cyc_nxt;
      r_stb   <= w_stb_nxt;
      r_err   <= w_err_nxt;
      r_cti   <= w_cti_nxt;
      r_adr   <= w_adr_nxt;
      r_sel   <= w_sel_nxt;
      r_dat   <= w_dat_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Reset gates the two combinational outputs directly so they respond without a clock.
  assign o_fifo_ack = w_pop & i_reset_n;
  assign o_idle     = (r_state == S_IDLE) | ~i_reset_n;

  assign o_wb_cyc = r_cyc;
  assign o_wb_stb = r_stb;
  assign o_wb_we  = 1'b1;
  assign o_wb_adr = r_adr;
  assign o_wb_sel = r_sel;
  assign o_wb_dat = r_dat;
  assign o_wb_cti = r_cti;
  assign o_wb_bte = 2'b00;
  assign o_err    = r_err;

endmodule

// File: tb/tb_zap_wb_fifo_drain.sv
// Bench for zap_wb_fifo_drain: FWFT FIFO source, Wishbone slave with wait states and
// error injection, table of burst scenarios plus hand-timed single-beat and reset sequences.
module tb_zap_wb_fifo_drain;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic [67:0] i_fifo_data;
  logic        i_fifo_empty_n;
  logic        o_fifo_ack;
  logic        o_wb_cyc, o_wb_stb, o_wb_we;
  logic [31:0] o_wb_adr, o_wb_dat;
  logic [3:0]  o_wb_sel;
  logic [2:0]  o_wb_cti;
  logic [1:0]  o_wb_bte;
  logic        i_wb_ack, i_wb_err;
  logic        o_err, o_idle;

  zap_wb_fifo_drain #(.MAX_BURST(8)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_fifo_data(i_fifo_data), .i_fifo_empty_n(i_fifo_empty_n), .o_fifo_ack(o_fifo_ack),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
    .o_wb_adr(o_wb_adr), .o_wb_sel(o_wb_sel), .o_wb_dat(o_wb_dat),
    .o_wb_cti(o_wb_cti), .o_wb_bte(o_wb_bte),
    .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err),
    .o_err(o_err), .o_idle(o_idle)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int               n_ent;
    logic [0:9][31:0] adr;
    int               ws;
    logic [31:0]      err_adr;
    int               exp_beats;
    logic [0:9][2:0]  exp_cti;
    int               exp_cycles;
    int               exp_errs;
    int               exp_pops_at_err;
  } vec_t;

  vec_t vecs[5];

  int checks = 0;
  int failures = 0;

  logic [67:0] fifo_q[$];
  logic [31:0] log_adr[$];
  logic [31:0] log_dat[$];
  logic [3:0]  log_sel[$];
  logic [2:0]  log_cti[$];

  int          pops, cyc_rises, errs_seen, pops_at_err, viol, stb_age, ws;
  logic        rec_ack, prev_cyc, err_armed, prev_wait;
  logic [31:0] err_adr;
  logic [31:0] p_adr, p_dat;
  logic [3:0]  p_sel;
  logic [2:0]  p_cti;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [67:0] mk_entry(input logic [31:0] adr);
    return {adr, adr[5:2], ~adr};
  endfunction

  task automatic drive_fifo();
    i_fifo_empty_n = (fifo_q.size() != 0);
    i_fifo_data    = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endtask

  // One clock: apply the pop seen last cycle, drive FIFO/slave, then sample at the falling edge.
  task automatic step();
    logic hit;
    @(posedge i_clk);
    #1;
    if (rec_ack && fifo_q.size() > 0) begin
      void'(fifo_q.pop_front());
      pops++;
    end
    drive_fifo();
    if (o_wb_stb) begin
      hit      = err_armed && (o_wb_adr == err_adr);
      i_wb_err = hit;
      i_wb_ack = !hit && (stb_age >= ws);
      if (hit) err_armed = 1'b0;
      stb_age++;
    end else begin
      i_wb_ack = 1'b0;
      i_wb_err = 1'b0;
      stb_age  = 0;
    end
    @(negedge i_clk);
    rec_ack = o_fifo_ack;
    if (o_fifo_ack && !i_fifo_empty_n) viol++;
    if (i_reset_n && (o_wb_we !== 1'b1 || o_wb_bte !== 2'b00)) viol++;
    if (o_wb_stb && !o_wb_cyc) viol++;
    if (i_reset_n && prev_wait &&
        (!o_wb_cyc || !o_wb_stb || o_wb_adr !== p_adr || o_wb_sel !== p_sel ||
         o_wb_dat !== p_dat || o_wb_cti !== p_cti)) viol++;
    prev_wait = i_reset_n && o_wb_stb && !i_wb_ack && !i_wb_err;
    p_adr = o_wb_adr; p_sel = o_wb_sel; p_dat = o_wb_dat; p_cti = o_wb_cti;
    if (o_wb_stb && (i_wb_ack || i_wb_err)) begin
      log_adr.push_back(o_wb_adr);
      log_dat.push_back(o_wb_dat);
      log_sel.push_back(o_wb_sel);
      log_cti.push_back(o_wb_cti);
    end
    if (o_wb_cyc && !prev_cyc) cyc_rises++;
    prev_cyc = o_wb_cyc;
    if (o_err) begin
      if (errs_seen == 0) pops_at_err = pops;
      errs_seen++;
    end
  endtask

  task automatic clear_log();
    log_adr.delete(); log_dat.delete(); log_sel.delete(); log_cti.delete();
    pops = 0; cyc_rises = 0; errs_seen = 0; pops_at_err = -1; viol = 0;
  endtask

  task automatic run_until_idle(input string tag, input int budget);
    int n = 0;
    step();
    n++;
    while (!(fifo_q.size() == 0 && o_idle && !o_wb_cyc) && n < budget) begin
      step();
      n++;
    end
    check($sformatf("%s drain within budget", tag), 32'(n < budget), 32'd1);
  endtask

  task automatic run_vec(input int k, input vec_t v);
    string t;
    t = $sformatf("vec%0d", k);
    clear_log();
    ws        = v.ws;
    err_adr   = v.err_adr;
    err_armed = (v.exp_errs > 0);
    for (int i = 0; i < v.n_ent; i++) fifo_q.push_back(mk_entry(v.adr[i]));
    run_until_idle(t, 400);
    check({t, " beats"}, 32'(log_adr.size()), 32'(v.exp_beats));
    for (int i = 0; i < v.exp_beats; i++) begin
      if (i < log_adr.size()) begin
        check($sformatf("%s beat%0d adr", t, i), log_adr[i], v.adr[i]);
        check($sformatf("%s beat%0d cti", t, i), 32'(log_cti[i]), 32'(v.exp_cti[i]));
        check($sformatf("%s beat%0d dat", t, i), log_dat[i], ~v.adr[i]);
        check($sformatf("%s beat%0d sel", t, i), 32'(log_sel[i]), 32'(v.adr[i][5:2]));
      end
    end
    check({t, " pops"}, 32'(pops), 32'(v.n_ent));
    check({t, " bus cycles"}, 32'(cyc_rises), 32'(v.exp_cycles));
    check({t, " err pulses"}, 32'(errs_seen), 32'(v.exp_errs));
    if (v.exp_errs > 0) check({t, " pops at err"}, 32'(pops_at_err), 32'(v.exp_pops_at_err));
    check({t, " protocol violations"}, 32'(viol), 32'd0);
  endtask

  initial begin
    // Contiguous three-beat burst with two wait states per beat.
    vecs[0] = '{n_ent: 3, adr: {32'h200, 32'h204, 32'h208, {7{32'h0}}}, ws: 2, err_adr: 32'h1,
                exp_beats: 3, exp_cti: {3'b010, 3'b010, 3'b111, {7{3'b000}}},
                exp_cycles: 1, exp_errs: 0, exp_pops_at_err: -1};
    // Ten contiguous entries split into 8 + 2 by MAX_BURST=8.
    vecs[1] = '{n_ent: 10,
                adr: {32'h1000, 32'h1004, 32'h1008, 32'h100C, 32'h1010,
                      32'h1014, 32'h1018, 32'h101C, 32'h1020, 32'h1024},
                ws: 0, err_adr: 32'h1, exp_beats: 10,
                exp_cti: {{7{3'b010}}, 3'b111, 3'b010, 3'b111},
                exp_cycles: 2, exp_errs: 0, exp_pops_at_err: -1};
    // Non-contiguous pair.
    vecs[2] = '{n_ent: 2, adr: {32'h300, 32'h400, {8{32'h0}}}, ws: 1, err_adr: 32'h1,
                exp_beats: 2, exp_cti: {3'b111, 3'b111, {8{3'b000}}},
                exp_cycles: 2, exp_errs: 0, exp_pops_at_err: -1};
    // Address wrap is not a continuation.
    vecs[3] = '{n_ent: 2, adr: {32'hFFFFFFFC, 32'h0, {8{32'h0}}}, ws: 0, err_adr: 32'h1,
                exp_beats: 2, exp_cti: {3'b111, 3'b111, {8{3'b000}}},
                exp_cycles: 2, exp_errs: 0, exp_pops_at_err: -1};
    // Bus error on second beat; third entry goes out as a fresh cycle.
    vecs[4] = '{n_ent: 3, adr: {32'h500, 32'h504, 32'h508, {7{32'h0}}}, ws: 0, err_adr: 32'h504,
                exp_beats: 3, exp_cti: {3'b010, 3'b010, 3'b111, {7{3'b000}}},
                exp_cycles: 2, exp_errs: 1, exp_pops_at_err: 2};

    i_reset_n = 1'b0;
    i_fifo_data = '0; i_fifo_empty_n = 1'b0;
    i_wb_ack = 1'b0; i_wb_err = 1'b0;
    rec_ack = 1'b0; prev_cyc = 1'b0; prev_wait = 1'b0; err_armed = 1'b0;
    err_adr = 32'h1; stb_age = 0; ws = 0;
    p_adr = '0; p_dat = '0; p_sel = '0; p_cti = '0;
    clear_log();
    #1;
    check("reset cyc", 32'(o_wb_cyc), 32'd0);
    check("reset stb", 32'(o_wb_stb), 32'd0);
    check("reset err", 32'(o_err), 32'd0);
    check("reset cti", 32'(o_wb_cti), 32'd0);
    check("reset adr", o_wb_adr, 32'd0);
    check("reset sel", 32'(o_wb_sel), 32'd0);
    check("reset dat", o_wb_dat, 32'd0);
    check("reset idle", 32'(o_idle), 32'd1);
    check("reset fifo_ack", 32'(o_fifo_ack), 32'd0);
    repeat (2) step();
    i_reset_n = 1'b1;
    #1 rec_ack = o_fifo_ack;
    step();
    check("post-reset idle", 32'(o_idle), 32'd1);
    check("post-reset we", 32'(o_wb_we), 32'd1);

    // Single entry, cycle-exact timing.
    clear_log();
    ws = 0;
    fifo_q.push_back({32'h100, 4'hF, 32'hA5A5A5A5});
    step();
    check("single t pop", 32'(o_fifo_ack), 32'd1);
    check("single t cyc", 32'(o_wb_cyc), 32'd0);
    step();
    check("single t+1 cyc", 32'(o_wb_cyc), 32'd1);
    check("single t+1 stb", 32'(o_wb_stb), 32'd0);
    check("single t+1 pop", 32'(o_fifo_ack), 32'd0);
    step();
    check("single t+2 stb", 32'(o_wb_stb), 32'd1);
    check("single t+2 cti", 32'(o_wb_cti), 32'b111);
    check("single t+2 adr", o_wb_adr, 32'h100);
    check("single t+2 sel", 32'(o_wb_sel), 32'hF);
    check("single t+2 dat", o_wb_dat, 32'hA5A5A5A5);
    step();
    check("single end cyc", 32'(o_wb_cyc), 32'd0);
    check("single end stb", 32'(o_wb_stb), 32'd0);
    check("single end idle", 32'(o_idle), 32'd1);
    check("single end cti", 32'(o_wb_cti), 32'd0);
    check("single pops", 32'(pops), 32'd1);

    for (int k = 0; k < 5; k++) run_vec(k, vecs[k]);

    // Reset asserted while a beat is waiting for its ack.
    clear_log();
    ws = 10;
    err_armed = 1'b0;
    fifo_q.push_back(mk_entry(32'h700));
    fifo_q.push_back(mk_entry(32'h704));
    for (int n = 0; n < 20 && !o_wb_stb; n++) step();
    check("rst-mid stb before", 32'(o_wb_stb), 32'd1);
    check("rst-mid cti before", 32'(o_wb_cti), 32'b010);
    #2 i_reset_n = 1'b0;
    #1;
    check("rst-mid cyc async", 32'(o_wb_cyc), 32'd0);
    check("rst-mid stb async", 32'(o_wb_stb), 32'd0);
    check("rst-mid cti async", 32'(o_wb_cti), 32'd0);
    check("rst-mid fifo_ack async", 32'(o_fifo_ack), 32'd0);
    check("rst-mid idle async", 32'(o_idle), 32'd1);
    for (int n = 0; n < 3; n++) begin
      step();
      check($sformatf("rst-mid fifo_ack held %0d", n), 32'(o_fifo_ack), 32'd0);
    end
    check("rst-mid pops during reset", 32'(pops), 32'd1);
    ws = 0;
    i_reset_n = 1'b1;
    #1 rec_ack = o_fifo_ack;
    log_adr.delete(); log_cti.delete(); log_dat.delete(); log_sel.delete();
    run_until_idle("rst-mid", 100);
    check("rst-mid resume beats", 32'(log_adr.size()), 32'd1);
    if (log_adr.size() > 0) begin
      check("rst-mid resume adr", log_adr[0], 32'h704);
      check("rst-mid resume cti", 32'(log_cti[0]), 32'b111);
    end
    check("rst-mid total pops", 32'(pops), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
